demux1to5_stream: RTL and testbench
===================================

# demux1to5_stream

Registered 1-to-5 stream demultiplexer with valid/ready handshaking. It accepts one data word per cycle from a single producer and delivers it to exactly one of five consumer lanes selected by a 3-bit destination code. It is the distribution counterpart of the 5-to-1 selection muxes in the datapath, used where one result bus fans out to five sinks that can each stall independently. Lane numbering and the out-of-range fallback match the 5-to-1 mux convention, so a select code means the same lane on both sides.

## Interface
- DATA_WIDTH, 64, width of the data word.
- clk  input  1  clock; all state updates on rising edge.
- arstn  input  1  asynchronous active-low reset.
- i_valid  input  1  producer has a word on i_data.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  DATA_WIDTH  producer data.
- i_sel  input  3  destination lane; 0–4 are valid, 5–7 are out of range.
- o_valid  output  5  bit k set means lane k holds a word.
- i_ready  input  5  bit k set means lane k consumer accepts this cycle.
- o_data  output  DATA_WIDTH  held word, shared by all lanes; meaningful only on the lane whose o_valid is set.
- o_sel_err  output  1  sticky flag: an out-of-range i_sel was accepted.
- i_err_clr  input  1  synchronous clear of o_sel_err.

## Operation
- Reset is asynchronous and active-low (arstn).
- Storage is a single holding register: data_q, dest_q[2:0] and full_q.
- Output decode:
  - o_valid[k] = full_q && (dest_q == k), one-hot or zero.
  - o_data = data_q.
- Drain: drain = full_q && i_ready[dest_q]. Ready bits of non-destination lanes are ignored.
- o_ready = !full_q || drain. This is a combinational path from i_ready. Full throughput: one word per cycle when the destination is ready.
- Accept: accept = i_valid && o_ready. On accept:
  - data_q <= i_data.
  - dest_q <= (i_sel <= 4) ? i_sel : 0. Out-of-range codes go to lane 0.
  - full_q <= 1.
- Drain without accept: full_q <= 0. data_q and dest_q hold their values.
- Drain and accept in the same cycle: the register reloads with the new word and full_q stays 1. No bubble.
- No accept and no drain: all state holds.
- Stability: while full_q=1 and the destination is not ready, o_data, dest_q and o_valid must not change. This holds regardless of i_valid, i_sel and i_data.
- Error flag:
  - If accept occurs with i_sel > 4, o_sel_err <= 1 (set).
  - Else if i_err_clr, o_sel_err <= 0.
  - Set has priority over clear in the same cycle.
- The producer must keep i_valid, i_data and i_sel stable until accepted. The block does not check this.
- The block never drops or duplicates a word. Every accept is followed by exactly one drain, on the lane latched at accept time.

## Timing
- Reset values: full_q=0, dest_q=0, data_q=0, o_sel_err=0. Therefore o_valid=5'b0, o_data=0, o_ready=1.
- Reset asserted mid-transfer: the held word is discarded immediately and asynchronously. Outputs go to their reset values in the same cycle.
- Latency: a word accepted at edge N appears on o_valid/o_data after edge N. It is consumed at the first edge where the destination lane's i_ready=1.
- Minimum latency from input to a lane is 1 cycle.
- Sustained throughput is 1 word per cycle.
- A word on a stalled lane blocks all lanes (head-of-line blocking). This is intended; there is no per-lane buffering.
- i_ready bits may toggle freely. Only the destination bit is sampled, and only while full_q=1.
- i_err_clr has no effect when an out-of-range accept occurs in the same cycle.

## Test plan
- Reset and idle:
  - Stimulus: arstn low, then high, i_valid=0.
  - Required: o_valid=0, o_data=0, o_ready=1, o_sel_err=0, with no change over 10 cycles.
- Lane sweep:
  - Stimulus: i_ready=5'b11111; send 0xA0..0xA4 back-to-back with i_sel=0..4.
  - Required: o_valid is 00001, 00010, 00100, 01000, 10000 on consecutive cycles; o_data matches each word; o_ready stays 1 throughout.
- Stall and hold:
  - Stimulus: send 0x1234 to lane 3 with i_ready[3]=0 for 4 cycles; keep i_valid=1 with a new word 0x5678, lane 1.
  - Required: o_ready=0, o_valid=01000 and o_data=0x1234 stay stable for 4 cycles.
  - Stimulus: set i_ready[3]=1.
  - Required: on the next cycle o_valid=00010 and o_data=0x5678.
- Non-destination ready ignored:
  - Stimulus: word on lane 2 with i_ready=5'b11011.
  - Required: word held and o_ready=0 until i_ready[2]=1.
- Out-of-range select:
  - Stimulus: send 0xBEEF with i_sel=6.
  - Required: o_valid=00001, o_data=0xBEEF, o_sel_err=1.
  - Stimulus: pulse i_err_clr; then pulse it again in the same cycle as an i_sel=7 accept.
  - Required: the first pulse clears o_sel_err to 0; the second leaves o_sel_err=1.
- Reset mid-operation:
  - Stimulus: word held on lane 4 (stalled); assert arstn asynchronously between clock edges.
  - Required: o_valid=0 and o_ready=1 immediately. After release, the next word is accepted normally with no trace of the old one.

Source files
------------

// File: rtl/demux1to5_stream.sv
// demux1to5_stream
//   Registered 1-to-5 stream demultiplexer with valid/ready handshaking.
//   A single holding register takes one word per cycle from the producer and
//   presents it to the consumer lane chosen by i_sel. An out-of-range select
//   (5..7) falls back to lane 0, as the matching 5-to-1 muxes do.
//
// Ports
//   clk        clock, rising edge
//   arstn      asynchronous active-low reset
//   i_valid    producer word present on i_data / i_sel
//   o_ready    block accepts a word this cycle (combinational from i_ready)
//   i_data     producer data word
//   i_sel      destination lane code, 0..4 valid
//   o_valid    one-hot (or zero) lane valid
//   i_ready    per-lane consumer ready
//   o_data     held word, shared by all lanes
//   o_sel_err  sticky flag: an out-of-range select was accepted
//   i_err_clr  synchronous clear of o_sel_err (set wins)
module demux1to5_stream #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_sel,
  output logic [4:0]            o_valid,
  input  logic [4:0]            i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sel_err,
  input  logic                  i_err_clr
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            dest_q, dest_d;
  logic                  full_q, full_d;
  logic                  err_q,  err_d;

  logic drain;
  logic accept;
  logic sel_oob;

  // Lane decode; dest_q is only ever 0..4, so at most one bit is set.
  always_comb begin
    o_valid = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      o_valid[k] = full_q && (dest_q == 3'(k));
    end
  end

  // Masking with o_valid samples only the destination lane's ready bit.
  assign drain     = |(o_valid & i_ready);
  assign o_ready   = !full_q || drain;
  assign accept    = i_valid && o_ready;
  assign sel_oob   = (i_sel > 3'd4);
  assign o_data    = data_q;
  assign o_sel_err = err_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    dest_d = dest_q;
    err_d  = err_q;

    // Accept takes precedence over drain: a simultaneous drain+accept simply
    // reloads the register and leaves it full, giving one word per cycle.
    if (accept) begin
      data_d = i_data;
      dest_d = sel_oob ? '0 : i_sel;
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end

    if (accept && sel_oob) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      full_q <= 1'b0;
      data_q <= '0;
      dest_q <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      dest_q <= dest_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_demux1to5_stream.sv
// Testbench for demux1to5_stream: directed vector table, hand-written reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_demux1to5_stream;

  localparam int unsigned DW = 64;

  logic          clk;
  logic          arstn;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [2:0]    i_sel;
  logic [4:0]    o_valid;
  logic [4:0]    i_ready;
  logic [DW-1:0] o_data;
  logic          o_sel_err;
  logic          i_err_clr;

  demux1to5_stream #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_sel     (i_sel),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_sel_err (o_sel_err),
    .i_err_clr (i_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One directed cycle: drive, check o_ready before the edge, clock, check
  // the registered outputs just after the edge.
  typedef struct {
    logic          v;
    logic [2:0]    sel;
    logic [DW-1:0] d;
    logic [4:0]    rdy;
    logic          clr;
    logic          e_rdy;
    logic [4:0]    e_valid;
    logic [DW-1:0] e_data;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input vec_t t, input string tag);
    i_valid   = t.v;
    i_sel     = t.sel;
    i_data    = t.d;
    i_ready   = t.rdy;
    i_err_clr = t.clr;
    #1;
    check({tag, ".o_ready"}, 64'(o_ready), 64'(t.e_rdy));
    @(posedge clk);
    #1;
    check({tag, ".o_valid"}, 64'(o_valid), 64'(t.e_valid));
    check({tag, ".o_data"}, o_data, t.e_data);
    check({tag, ".o_sel_err"}, 64'(o_sel_err), 64'(t.e_err));
  endtask

  // Reference model: at most one word in flight, held as {data, lane}.
  typedef struct {
    logic [DW-1:0] data;
    int            lane;
  } word_t;

  word_t         slot[$];
  logic [DW-1:0] m_last;
  logic          m_err;
  int            n_acc;
  int            n_drn;

  initial begin
    vec_t   t;
    logic   want;
    logic   exp_rdy;
    logic   acc;
    logic   drn;
    logic [4:0] exp_v;
    logic [2:0] p_sel;
    logic [DW-1:0] p_data;

    arstn = 1'b0; i_valid = 1'b0; i_sel = '0; i_data = '0;
    i_ready = '0; i_err_clr = 1'b0;

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst.o_valid", 64'(o_valid), 64'd0);
    check("rst.o_data", o_data, 64'd0);
    check("rst.o_ready", 64'(o_ready), 64'd1);
    check("rst.o_sel_err", 64'(o_sel_err), 64'd0);
    arstn = 1'b1;
    for (int i = 0; i < 10; i++)
      step('{1'b0, 3'd0, 64'd0, 5'h1F, 1'b0, 1'b1, 5'b0, 64'd0, 1'b0}, "idle");

    // Lane sweep, back to back.
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 3'(i), 64'hA0 + 64'(i), 5'h1F, 1'b0, 1'b1, 5'(1 << i), 64'hA0 + 64'(i), 1'b0});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'h1F, 1'b0, 1'b1, 5'b0, 64'hA4, 1'b0});
    // Stall and hold on lane 3, next word queued for lane 1.
    tbl.push_back('{1'b1, 3'd3, 64'h1234, 5'h1F, 1'b0, 1'b1, 5'b01000, 64'h1234, 1'b0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b1, 3'd1, 64'h5678, 5'b10111, 1'b0, 1'b0, 5'b01000, 64'h1234, 1'b0});
    tbl.push_back('{1'b1, 3'd1, 64'h5678, 5'h1F, 1'b0, 1'b1, 5'b00010, 64'h5678, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'h1F, 1'b0, 1'b1, 5'b0, 64'h5678, 1'b0});
    // Non-destination ready bits ignored.
    tbl.push_back('{1'b1, 3'd2, 64'h22, 5'b00000, 1'b0, 1'b1, 5'b00100, 64'h22, 1'b0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 3'd0, 64'h33, 5'b11011, 1'b0, 1'b0, 5'b00100, 64'h22, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'b00100, 1'b0, 1'b1, 5'b0, 64'h22, 1'b0});
    // Out-of-range select, clear, and set-beats-clear.
    tbl.push_back('{1'b1, 3'd6, 64'hBEEF, 5'b0, 1'b0, 1'b1, 5'b00001, 64'hBEEF, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'b00001, 1'b0, 1'b1, 5'b0, 64'hBEEF, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'b0, 1'b1, 1'b1, 5'b0, 64'hBEEF, 1'b0});
    tbl.push_back('{1'b1, 3'd7, 64'hC0DE, 5'b0, 1'b1, 1'b1, 5'b00001, 64'hC0DE, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'b0, 1'b0, 1'b0, 5'b00001, 64'hC0DE, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'b00001, 1'b0, 1'b1, 5'b0, 64'hC0DE, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 64'd0, 5'b0, 1'b1, 1'b1, 5'b0, 64'hC0DE, 1'b0});

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    // Reset mid-operation: word stalled on lane 4, reset between edges.
    step('{1'b1, 3'd4, 64'h4444, 5'b0, 1'b0, 1'b1, 5'b10000, 64'h4444, 1'b0}, "pre_rst");
    i_valid = 1'b0;
    #2;
    arstn = 1'b0;
    #1;
    check("midrst.o_valid", 64'(o_valid), 64'd0);
    check("midrst.o_ready", 64'(o_ready), 64'd1);
    check("midrst.o_data", o_data, 64'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    step('{1'b1, 3'd1, 64'h5555, 5'b0, 1'b0, 1'b1, 5'b00010, 64'h5555, 1'b0}, "post_rst");
    step('{1'b0, 3'd0, 64'd0, 5'h1F, 1'b0, 1'b1, 5'b0, 64'h5555, 1'b0}, "post_drain");

    // Randomized traffic; model starts empty with data 0x5555 held.
    m_last = 64'h5555;
    m_err  = 1'b0;
    n_acc  = 0;
    n_drn  = 0;
    want   = 1'b0;
    p_sel  = '0;
    p_data = '0;
    for (int c = 0; c < 600; c++) begin
      // Producer keeps its word stable until accepted.
      if (!want && ($urandom_range(0, 3) != 0)) begin
        want   = 1'b1;
        p_sel  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        p_data = {$urandom, $urandom};
      end
      i_valid   = want;
      i_sel     = p_sel;
      i_data    = p_data;
      i_ready   = 5'($urandom);
      i_err_clr = ($urandom_range(0, 15) == 0);
      #1;
      drn     = (slot.size() != 0) && i_ready[slot[0].lane];
      exp_rdy = (slot.size() == 0) || drn;
      acc     = want && exp_rdy;
      check("rnd.o_ready", 64'(o_ready), 64'(exp_rdy));
      if (drn) begin
        void'(slot.pop_front());
        n_drn++;
      end
      if (acc) begin
        slot.push_back('{p_data, (p_sel > 3'd4) ? 0 : int'(p_sel)});
        m_last = p_data;
        n_acc++;
        want = 1'b0;
      end
      if (acc && p_sel > 3'd4) m_err = 1'b1;
      else if (i_err_clr)      m_err = 1'b0;
      exp_v = '0;
      if (slot.size() != 0) exp_v[slot[0].lane] = 1'b1;
      @(posedge clk);
      #1;
      check("rnd.o_valid", 64'(o_valid), 64'(exp_v));
      check("rnd.o_data", o_data, m_last);
      check("rnd.o_sel_err", 64'(o_sel_err), 64'(m_err));
    end
    check("rnd.accept_vs_drain", 64'(n_acc), 64'(n_drn + slot.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
